// File: rtl/vpf_pattern_gen.sv
// Valid-pattern-flag stimulus generator: rotating N-hit patterns with gaps, cross-checked against a cluster counter.
// Checks each driven vector against the counter's reply LATENCY cycles later; busy_o brackets a run, done_o pulses at the end.
module vpf_pattern_gen #(
  parameter int MXVPF      = 768,
  parameter int LATENCY    = 11,
  parameter int OVF_THRESH = 8
) (
  input  logic             clock4x,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [9:0]       nhits_i,
  input  logic [9:0]       stride_i,
  input  logic [15:0]      npat_i,
  input  logic [3:0]       gap_i,
  input  logic [10:0]      cnt_i,
  input  logic             overflow_i,
  output logic [MXVPF-1:0] vpfs_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [15:0]      err_cnt_o
);

  localparam int OW = $clog2(MXVPF);

  typedef enum logic [2:0] {IDLE, RUN, GAP, FLUSH, DONE} state_t;

  typedef struct packed {
    logic        vld;
    logic [10:0] cnt;
    logic        ovf;
  } chk_t;

  state_t           state_q, state_d;
  logic [10:0]      nhits_q, nhits_d;
  logic [OW-1:0]    stride_q, stride_d;
  logic [OW-1:0]    offset_q, offset_d;
  logic [OW:0]      offset_sum;
  logic [15:0]      npat_q, npat_d;
  logic [15:0]      pat_cnt_q, pat_cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [15:0]      flush_cnt_q, flush_cnt_d;
  logic [MXVPF-1:0] mask;
  logic [MXVPF-1:0] vpfs_q, vpfs_d;
  logic             err_q, err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  chk_t             dl_q [LATENCY];
  chk_t             push;
  logic             mismatch;

  // Expected counter reply for the vector currently on vpfs_o.
  always_comb begin
    push     = '0;
    push.vld = (state_q == RUN) || (state_q == GAP);
    push.cnt = (state_q == RUN) ? nhits_q : 11'd0;
    push.ovf = (32'(push.cnt) > OVF_THRESH);
  end

  assign mismatch = dl_q[LATENCY-1].vld &&
                    ((cnt_i != dl_q[LATENCY-1].cnt) || (overflow_i != dl_q[LATENCY-1].ovf));

  always_comb begin
    state_d     = state_q;
    nhits_d     = nhits_q;
    stride_d    = stride_q;
    npat_d      = npat_q;
    gap_d       = gap_q;
    offset_d    = offset_q;
    pat_cnt_d   = pat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    offset_sum  = {1'b0, offset_q} + {1'b0, stride_q};

    if (mismatch) begin
      err_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          nhits_d   = (32'(nhits_i) > MXVPF) ? 11'(MXVPF) : {1'b0, nhits_i};
          stride_d  = OW'(32'(stride_i) % MXVPF);
          npat_d    = npat_i;
          gap_d     = gap_i;
          offset_d  = '0;
          pat_cnt_d = '0;
          err_d     = 1'b0;
          err_cnt_d = '0;
          if (npat_i == 16'd0) begin
            state_d     = FLUSH;
            flush_cnt_d = 16'(LATENCY - 1);
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        offset_d  = (offset_sum >= (OW+1)'(MXVPF)) ? OW'(offset_sum - (OW+1)'(MXVPF))
                                                   : offset_sum[OW-1:0];
        pat_cnt_d = pat_cnt_q + 16'd1;
        if (gap_q != 4'd0) begin
          state_d   = GAP;
          gap_cnt_d = gap_q - 4'd1;
        end else if (pat_cnt_d == npat_q) begin
          state_d     = FLUSH;
          flush_cnt_d = 16'(LATENCY - 1);
        end else begin
          state_d = RUN;
        end
      end
      GAP: begin
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else if (pat_cnt_q == npat_q) begin
          state_d     = FLUSH;
          flush_cnt_d = 16'(LATENCY - 1);
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 16'd0) state_d = DONE;
        else                      flush_cnt_d = flush_cnt_q - 16'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The output register is loaded from next-state values so the pattern appears in its RUN cycle.
  always_comb begin
    for (int i = 0; i < MXVPF; i++) mask[i] = (i < 32'(nhits_d));
    vpfs_d = '0;
    if (state_d == RUN) vpfs_d = (mask << offset_d) | (mask >> (MXVPF - 32'(offset_d)));
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      nhits_q     <= '0;
      stride_q    <= '0;
      npat_q      <= '0;
      gap_q       <= '0;
      offset_q    <= '0;
      pat_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      flush_cnt_q <= '0;
      vpfs_q      <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      for (int i = 0; i < LATENCY; i++) dl_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      nhits_q     <= nhits_d;
      stride_q    <= stride_d;
      npat_q      <= npat_d;
      gap_q       <= gap_d;
      offset_q    <= offset_d;
      pat_cnt_q   <= pat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      vpfs_q      <= vpfs_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      dl_q[0]     <= push;
      for (int i = 1; i < LATENCY; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign vpfs_o    = vpfs_q;
  assign busy_o    = (state_q == RUN) || (state_q == GAP) || (state_q == FLUSH);
  assign done_o    = (state_q == DONE);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_vpf_pattern_gen.sv
// Bench for vpf_pattern_gen: cycle-by-cycle scoreboard of vpfs_o/busy_o/done_o plus a delayed popcount counter model.
module tb_vpf_pattern_gen;
  localparam int MXVPF      = 768;
  localparam int LATENCY    = 11;
  localparam int OVF_THRESH = 8;

  logic             clock4x = 1'b0;
  logic             reset_n = 1'b0;
  logic             start_i = 1'b0;
  logic [9:0]       nhits_i = '0;
  logic [9:0]       stride_i = '0;
  logic [15:0]      npat_i = '0;
  logic [3:0]       gap_i = '0;
  logic [10:0]      cnt_i;
  logic             overflow_i;
  logic [MXVPF-1:0] vpfs_o;
  logic             busy_o, done_o, err_o;
  logic [15:0]      err_cnt_o;

  typedef struct {
    logic [MXVPF-1:0] v;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic force_mode = 1'b0;
  logic [10:0] mdl_q [LATENCY];

  vpf_pattern_gen #(.MXVPF(MXVPF), .LATENCY(LATENCY), .OVF_THRESH(OVF_THRESH)) dut (
    .clock4x(clock4x), .reset_n(reset_n), .start_i(start_i), .nhits_i(nhits_i),
    .stride_i(stride_i), .npat_i(npat_i), .gap_i(gap_i), .cnt_i(cnt_i),
    .overflow_i(overflow_i), .vpfs_o(vpfs_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clock4x = ~clock4x;

  // Cluster counter model: popcount of vpfs_o, returned LATENCY cycles later.
  always @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) mdl_q[i] <= '0;
    end else begin
      mdl_q[0] <= 11'($countones(vpfs_o));
      for (int i = 1; i < LATENCY; i++) mdl_q[i] <= mdl_q[i-1];
    end
  end

  always_comb begin
    cnt_i = mdl_q[LATENCY-1];
    if (force_mode && cnt_i != 11'd0) cnt_i = 11'd5;
    overflow_i = (32'(cnt_i) > OVF_THRESH);
  end

  function automatic logic [MXVPF-1:0] exp_pat(int n, int off);
    logic [MXVPF-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[(off + k) % MXVPF] = 1'b1;
    return v;
  endfunction

  task automatic push_exp(logic [MXVPF-1:0] v, logic busy, logic done);
    exp_t e;
    e.v = v; e.busy = busy; e.done = done;
    sb.push_back(e);
  endtask

  // Starts one run, scrambling inputs (including stray start pulses) while it is in progress.
  task automatic run_case(string name, int nh, int st, int np, int gp, int exp_errs);
    exp_t e;
    int   n, s, off, cyc;
    n = (nh > MXVPF) ? MXVPF : nh;
    s = st % MXVPF;
    off = 0;
    for (int p = 0; p < np; p++) begin
      push_exp(exp_pat(n, off), 1'b1, 1'b0);
      for (int g = 0; g < gp; g++) push_exp('0, 1'b1, 1'b0);
      off = (off + s) % MXVPF;
    end
    for (int f = 0; f < LATENCY; f++) push_exp('0, 1'b1, 1'b0);
    push_exp('0, 1'b0, 1'b1);

    @(negedge clock4x);
    nhits_i = 10'(nh); stride_i = 10'(st); npat_i = 16'(np); gap_i = 4'(gp);
    start_i = 1'b1;
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clock4x);
      e = sb.pop_front();
      n_cmp++;
      if (vpfs_o !== e.v) begin
        n_bad++;
        $display("FAIL %s vpfs cyc%0d got %h want %h", name, cyc, vpfs_o, e.v);
      end
      n_cmp++;
      if ({busy_o, done_o} !== {e.busy, e.done}) begin
        n_bad++;
        $display("FAIL %s busy/done cyc%0d got %b%b want %b%b", name, cyc, busy_o, done_o, e.busy, e.done);
      end
      if (e.done) begin
        n_cmp++;
        if (err_cnt_o !== 16'(exp_errs)) begin
          n_bad++;
          $display("FAIL %s err_cnt got %0d want %0d", name, err_cnt_o, exp_errs);
        end
        n_cmp++;
        if (err_o !== (exp_errs != 0)) begin
          n_bad++;
          $display("FAIL %s err got %b want %b", name, err_o, exp_errs != 0);
        end
      end
      start_i  = (sb.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      nhits_i  = 10'($urandom);
      stride_i = 10'($urandom);
      npat_i   = 16'($urandom);
      gap_i    = 4'($urandom);
      cyc++;
    end
    @(negedge clock4x);
    n_cmp++;
    if ({busy_o, done_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s idle_after got %b%b want 00", name, busy_o, done_o);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock4x);
    n_cmp++;
    if ({vpfs_o, busy_o, done_o, err_o, err_cnt_o} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs got vpfs=%h busy=%b done=%b err=%b cnt=%0d want all 0",
               vpfs_o, busy_o, done_o, err_o, err_cnt_o);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    run_case("basic", 3, 1, 4, 0, 0);
  endtask

  task automatic test_wrap();
    run_case("wrap", 4, 766, 3, 0, 0);
  endtask

  task automatic test_clamp();
    run_case("clamp", 1000, 5, 1, 1, 0);
  endtask

  task automatic test_forced_mismatch();
    force_mode = 1'b1;
    run_case("forced", 9, 3, 2, 2, 2);
    force_mode = 1'b0;
  endtask

  task automatic test_npat_zero();
    run_case("npat0", 7, 1, 0, 3, 0);
  endtask

  task automatic test_back_to_back();
    run_case("b2b_a", 20, 700, 5, 1, 0);
    run_case("b2b_b", 768, 767, 3, 15, 0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clock4x);
    nhits_i = 10'd5; stride_i = 10'd2; npat_i = 16'd10; gap_i = 4'd0;
    start_i = 1'b1;
    @(negedge clock4x);
    start_i = 1'b0;
    repeat (2) @(negedge clock4x);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, vpfs_o} !== '0) begin
      n_bad++;
      $display("FAIL midreset async got busy=%b vpfs=%h want 0", busy_o, vpfs_o);
    end
    repeat (2) begin
      @(negedge clock4x);
      n_cmp++;
      if ({done_o, busy_o} !== 2'b00) begin
        n_bad++;
        $display("FAIL midreset held got done=%b busy=%b want 00", done_o, busy_o);
      end
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock4x);
    n_cmp++;
    if ({done_o, busy_o, err_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset released got done=%b busy=%b err=%b want 000", done_o, busy_o, err_o);
    end
    run_case("after_reset", 3, 1, 4, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_clamp();
    test_forced_mismatch();
    test_npat_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vpf_pattern_gen.md
VPF_PATTERN_GEN -- requirements
Module: vpf_pattern_gen

Interface
REQ-001 Parameter MXVPF, default 768: width of generated valid-pattern-flag vector.
REQ-002 Parameter LATENCY, default 11: cycles from vpfs_o change to matching cnt_i/overflow_i from the cluster counter.
REQ-003 Parameter OVF_THRESH, default 8: count above which overflow is expected.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clock4x  in  1  sole clock, all logic rising-edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 start_i  in  1  single-cycle request to begin a run.
REQ-008 nhits_i  in  10  bits set per pattern (0..1023, clamped).
REQ-009 stride_i  in  10  rotation advance per pattern.
REQ-010 npat_i  in  16  patterns per run.
REQ-011 gap_i  in  4  all-zero cycles inserted after each pattern.
REQ-012 cnt_i  in  11  count returned by the cluster counter.
REQ-013 overflow_i  in  1  overflow returned by the cluster counter.
REQ-014 vpfs_o  out  MXVPF  registered stimulus vector.
REQ-015 busy_o  out  1  high from start acceptance until done.
REQ-016 done_o  out  1  one-cycle pulse at end of run.
REQ-017 err_o  out  1  sticky mismatch flag, cleared at next accepted start.
REQ-018 err_cnt_o  out  16  saturating mismatch count, cleared at next accepted start.

Function
REQ-019 FSM states IDLE, RUN, GAP, FLUSH, DONE; reset state IDLE.
REQ-020 IDLE: start_i=1 latches nhits, stride, npat, gap; clears offset, pattern counter, err_o, err_cnt_o; goes to RUN, or to FLUSH when npat_i=0.
REQ-021 start_i outside IDLE is ignored.
REQ-022 Effective hits N = min(nhits, MXVPF); effective stride S = stride mod MXVPF.
REQ-023 RUN, one cycle per pattern: vpfs_o = bits [N-1:0] set, rotated left by offset (mod MXVPF, wrapping bit MXVPF-1 to bit 0).
REQ-024 After each pattern: offset = (offset+S) mod MXVPF; pattern counter increments; next state GAP if gap>0, else RUN.
REQ-025 GAP: vpfs_o=0 for exactly gap cycles, then RUN.
REQ-026 After pattern npat (including its gap cycles) go to FLUSH; vpfs_o=0 for exactly LATENCY cycles, then DONE.
REQ-027 DONE lasts one cycle: done_o=1, busy_o=0, next state IDLE.
REQ-028 busy_o=1 in RUN, GAP, FLUSH.
REQ-029 Each RUN/GAP cycle pushes {valid=1, expcnt, expovf} into a LATENCY-deep delay line, with expcnt=N (RUN) or 0 (GAP) and expovf=(expcnt>OVF_THRESH); all other states push valid=0.
REQ-030 When the delay-line output is valid and cnt_i≠expcnt or overflow_i≠expovf: err_o←1 and err_cnt_o increments, holding at 65535.
REQ-031 Comparison timing: a vector driven on vpfs_o at cycle t is checked against cnt_i/overflow_i at cycle t+LATENCY.
REQ-032 Checking continues through FLUSH, so every pushed entry is compared before done_o.
REQ-033 Input changes after start acceptance have no effect on the run in progress.

Reset
REQ-034 reset_n low, asynchronously: state IDLE, vpfs_o=0, busy_o=0, done_o=0, err_o=0, err_cnt_o=0, offset=0, delay line all invalid.
REQ-035 Reset mid-run aborts the run with no done_o pulse; pending delay-line entries are discarded and never compared.

Verification
REQ-036 nhits=3, stride=1, npat=4, gap=0, counter model attached -> vpfs_o=0x7,0xE,0x1C,0x38 on consecutive cycles; done_o is LATENCY+1 cycles after the last pattern; err_cnt_o=0.
REQ-037 nhits=4, offset reaches 766 with stride=766 -> second pattern has bits 766,767,0,1 set.
REQ-038 nhits=1000, npat=1 -> vpfs_o all ones; expected count 768, overflow 1; no error.
REQ-039 nhits=9, npat=2, gap=2, cnt_i forced to 5 -> two pattern mismatches (count and overflow), gap entries match; err_o=1, err_cnt_o=2.
REQ-040 npat=0 -> busy_o high for LATENCY cycles, then a done_o pulse, and vpfs_o stays 0.
REQ-041 reset_n low during RUN -> vpfs_o=0 and busy_o=0 immediately, no done_o; start is accepted normally after release.
